switch_key_counter: RTL and testbench
=====================================

# switch_key_counter

Sequential source stage that produces the 4-bit binary value driving the two-digit binary-to-decimal 7-segment display converter on the DE10-Standard board. It debounces two active-low pushbuttons for up/down stepping, supports parallel load from slide switches and a free-running auto-increment mode, and holds the result in a register. Output V connects directly to the converter's 4-bit input V.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required before a key change is accepted (20 ms at 50 MHz); minimum 1.
- TICK_CYCLES, 50000000: auto-mode increment period in clock cycles (1 s at 50 MHz); minimum 1.
- CLOCK_50  in  1  system clock, 50 MHz, all state on rising edge.
- RESET  in  1  asynchronous, active-high; clears all state immediately.
- KEY_UP_N  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to clock.
- KEY_DN_N  in  1  raw pushbutton, active-low, asynchronous to clock.
- SW_LOAD  in  1  raw slide switch, 1 = load mode.
- SW_AUTO  in  1  raw slide switch, 1 = auto-increment mode.
- SW_D  in  4  raw slide switches, load value.
- V  out  4  registered count, unsigned 0..15.
- WRAP  out  1  one-cycle pulse when V wraps (15→0 or 0→15).

## Operation
- Synchronizers: every raw input (KEY_UP_N, KEY_DN_N, SW_LOAD, SW_AUTO, SW_D[3:0]) passes a 2-flop synchronizer; reset value 1 for keys, 0 for switches.
- Debouncer (one per key): debounced state reset to 1 (released); stability counter increments each cycle the synchronized key differs from the debounced state, clears to 0 on any cycle it matches. On the edge the counter reaches DEBOUNCE_CYCLES the debounced state flips and the counter clears. Glitches shorter than DEBOUNCE_CYCLES never change state.
- Press event: debounced 1→0 transition, one-cycle strobe. Release produces no event; holding a key yields exactly one step.
- Tick generator: counter runs only when synchronized AUTO=1 and LOAD=0; otherwise held at 0. Emits a one-cycle tick when it reaches TICK_CYCLES-1, then restarts at 0.
- Count update priority per cycle (highest first):
  1. LOAD=1: V ← SW_D (synchronized) every cycle; press events and ticks discarded; WRAP=0.
  2. Up and down events same cycle: cancel, V unchanged.
  3. Up event: V ← V+1 mod 16. Down event: V ← V−1 mod 16. Any concurrent tick discarded.
  4. Tick: V ← V+1 mod 16.
- WRAP: registered, asserted the cycle after an up-step from 15 or down-step from 0; never on load.
- Arithmetic: 4-bit unsigned, natural wrap; no saturation.

## Timing
- Reset values: V=0, WRAP=0, debounced keys=1, all counters 0, synchronizers as above. RESET deasserted mid-press: key must again be stable DEBOUNCE_CYCLES before an event.
- Key latency: raw key held low from before edge k; synchronized low at edge k+1; debounced flips at edge k+1+DEBOUNCE_CYCLES; V updates at edge k+2+DEBOUNCE_CYCLES; WRAP (if any) coincides with V update.
- Load latency: SW_LOAD/SW_D change sampled at edge k → V reflects SW_D at edge k+2; leaving load mode, V holds last loaded value.
- Auto: first increment TICK_CYCLES+2 edges after SW_AUTO rises (2 sync + full period); subsequent increments every TICK_CYCLES edges. Turning AUTO off restarts the period.
- Key press during load: debouncer still tracks, but the event is lost; no step after LOAD drops.

## Test plan
Use DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
- Reset: assert RESET mid-sequence with V=9 → V=0, WRAP=0 immediately, without clock edge.
- Debounce: KEY_UP_N low 3 cycles then high → V unchanged; low 10 cycles → V 0→1 exactly once, at edge k+6.
- Wrap: load 15, release LOAD, press up → V=0, WRAP high one cycle; press down → V=15, WRAP high one cycle.
- Simultaneous: both keys pressed same edge from V=5 → V stays 5, WRAP=0.
- Load priority: SW_LOAD=1, SW_D=4'b1010, AUTO=1, key up pressed → V=10 at edge k+2, stays 10; no increments until LOAD=0.
- Auto: AUTO=1 from V=14 → V=15 after 10 edges, V=0 with WRAP pulse 8 edges later; up key event colliding with tick → single increment only.

Source files
------------

// File: rtl/switch_key_counter.sv
// switch_key_counter: 4-bit up/down/load/auto counter that drives the
// two-digit binary-to-decimal 7-segment converter on the DE10-Standard.
// Raw keys and switches are synchronized, and the keys are debounced.
// Key presses become single-cycle step events.
// Count updates follow a fixed priority: load, then cancel, then key step, then tick.
module switch_key_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY_UP_N,
  input  logic       KEY_DN_N,
  input  logic       SW_LOAD,
  input  logic       SW_AUTO,
  input  logic [3:0] SW_D,
  output logic [3:0] V,
  output logic       WRAP
);

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1 before the state
  // flips, so it never needs to hold DEBOUNCE_CYCLES itself.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  // Synchronizer bit layout: {SW_D[3:0], SW_AUTO, SW_LOAD, KEY_DN_N, KEY_UP_N}.
  // Keys reset to 1 (released). Switches reset to 0.
  localparam logic [7:0] SYNC_RST = 8'b0000_0011;

  logic [7:0]         sync1_q;
  logic [7:0]         sync2_q;
  logic [1:0]         key_s;
  logic               load_s;
  logic               auto_s;
  logic [3:0]         swd_s;

  logic [1:0]         db_q;
  logic [1:0]         db_d;
  logic [1:0]         db_prev_q;
  logic [1:0][CW-1:0] cnt_q;
  logic [1:0][CW-1:0] cnt_d;
  logic [1:0]         press_s;
  logic               up_ev_s;
  logic               dn_ev_s;

  logic               run_s;
  logic [TW-1:0]      tcnt_q;
  logic [TW-1:0]      tcnt_d;
  logic               tick_q;
  logic               tick_d;

  logic [3:0]         v_q;
  logic [3:0]         v_d;
  logic               wrap_q;
  logic               wrap_d;

  // Two-flop synchronizer for every raw board input.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
    end else begin
      sync1_q <= {SW_D, SW_AUTO, SW_LOAD, KEY_DN_N, KEY_UP_N};
      sync2_q <= sync1_q;
    end
  end

  assign key_s  = sync2_q[1:0];
  assign load_s = sync2_q[2];
  assign auto_s = sync2_q[3];
  assign swd_s  = sync2_q[7:4];

  // Debounce both keys. A key must differ from its accepted state for
  // DEBOUNCE_CYCLES consecutive cycles before the accepted state flips.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (key_s[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = '0;
        end else begin
          db_d[i]  = db_q[i];
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        db_d[i]  = db_q[i];
        cnt_d[i] = '0;
      end
    end
  end

  // Debounced key state, stability counters, and the previous state used for edge detection.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      db_q      <= 2'b11;
      db_prev_q <= 2'b11;
      cnt_q     <= '0;
    end else begin
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // A press is a debounced 1->0 transition. Releases produce no event.
  assign press_s = db_prev_q & ~db_q;
  assign up_ev_s = press_s[0];
  assign dn_ev_s = press_s[1];

  // Auto-mode period counter. It is held at zero whenever it is not running,
  // so re-enabling auto mode always starts a full period.
  assign run_s = auto_s & ~load_s;

  // Next state of the tick counter and the registered tick strobe.
  always_comb begin
    tcnt_d = tcnt_q;
    tick_d = 1'b0;
    if (run_s) begin
      if (tcnt_q == TICK_LAST) begin
        tcnt_d = '0;
        tick_d = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
        tick_d = 1'b0;
      end
    end else begin
      tcnt_d = '0;
      tick_d = 1'b0;
    end
  end

  // Tick counter and strobe registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      tcnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tick_q <= tick_d;
    end
  end

  // Count update, highest priority first: load, then up+down cancel, then a
  // single key step, then an auto tick. A tick that coincides with a key event is dropped.
  always_comb begin
    v_d    = v_q;
    wrap_d = 1'b0;
    if (load_s) begin
      v_d    = swd_s;
      wrap_d = 1'b0;
    end else if (up_ev_s && dn_ev_s) begin
      v_d    = v_q;
      wrap_d = 1'b0;
    end else if (up_ev_s) begin
      v_d    = v_q + 4'd1;
      wrap_d = (v_q == 4'd15);
    end else if (dn_ev_s) begin
      v_d    = v_q - 4'd1;
      wrap_d = (v_q == 4'd0);
    end else if (tick_q) begin
      v_d    = v_q + 4'd1;
      wrap_d = (v_q == 4'd15);
    end else begin
      v_d    = v_q;
      wrap_d = 1'b0;
    end
  end

  // Count and wrap-pulse output registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      v_q    <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      wrap_q <= wrap_d;
    end
  end

  assign V    = v_q;
  assign WRAP = wrap_q;

endmodule

// File: tb/tb_switch_key_counter.sv
// Directed bench for switch_key_counter with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
// Inputs change 1 time unit after a rising edge.
// Outputs are checked at the same point, away from the active edge.
module tb_switch_key_counter;

  logic       CLOCK_50 = 1'b0;
  logic       RESET    = 1'b1;
  logic       KEY_UP_N = 1'b1;
  logic       KEY_DN_N = 1'b1;
  logic       SW_LOAD  = 1'b0;
  logic       SW_AUTO  = 1'b0;
  logic [3:0] SW_D     = 4'd0;
  logic [3:0] V;
  logic       WRAP;

  int checks = 0;
  int errors = 0;

  switch_key_counter #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .KEY_UP_N(KEY_UP_N),
    .KEY_DN_N(KEY_DN_N),
    .SW_LOAD (SW_LOAD),
    .SW_AUTO (SW_AUTO),
    .SW_D    (SW_D),
    .V       (V),
    .WRAP    (WRAP)
  );

  // 10-unit clock period.
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges and land 1 unit after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Load a value: V reflects it 2 edges after sampling, and load is released afterwards.
  task automatic load_val(input logic [3:0] val);
    SW_D    = val;
    SW_LOAD = 1'b1;
    step(3);
    SW_LOAD = 1'b0;
    step(2);
  endtask

  // Press keys and advance to the edge where V updates (sampling edge k, update edge k+6).
  task automatic press(input logic up, input logic dn);
    KEY_UP_N = ~up;
    KEY_DN_N = ~dn;
    step(7);
  endtask

  task automatic release_keys();
    KEY_UP_N = 1'b1;
    KEY_DN_N = 1'b1;
    step(10);
  endtask

  initial begin
    // Reset state.
    step(2);
    check_eq("rst_v", V, 4'd0);
    check_eq("rst_wrap", {3'b000, WRAP}, 4'd0);
    RESET = 1'b0;
    step(2);
    check_eq("idle_v", V, 4'd0);

    // A glitch shorter than the debounce window is ignored.
    KEY_UP_N = 1'b0;
    step(3);
    KEY_UP_N = 1'b1;
    step(10);
    check_eq("glitch_v", V, 4'd0);

    // A long press steps exactly once, at edge k+6.
    KEY_UP_N = 1'b0;
    step(6);
    check_eq("deb_early", V, 4'd0);
    step(1);
    check_eq("deb_step", V, 4'd1);
    check_eq("deb_wrap", {3'b000, WRAP}, 4'd0);
    step(3);
    KEY_UP_N = 1'b1;
    step(10);
    check_eq("deb_once", V, 4'd1);

    // Load latency, then hold after leaving load mode.
    SW_D    = 4'd15;
    SW_LOAD = 1'b1;
    step(2);
    check_eq("load_early", V, 4'd1);
    step(1);
    check_eq("load_v", V, 4'd15);
    SW_LOAD = 1'b0;
    step(4);
    check_eq("load_hold", V, 4'd15);

    // Wrap up from 15, then wrap down from 0.
    press(1'b1, 1'b0);
    check_eq("wrap_up_v", V, 4'd0);
    check_eq("wrap_up_w", {3'b000, WRAP}, 4'd1);
    step(1);
    check_eq("wrap_up_w1", {3'b000, WRAP}, 4'd0);
    release_keys();
    press(1'b0, 1'b1);
    check_eq("wrap_dn_v", V, 4'd15);
    check_eq("wrap_dn_w", {3'b000, WRAP}, 4'd1);
    step(1);
    check_eq("wrap_dn_w1", {3'b000, WRAP}, 4'd0);
    release_keys();

    // Simultaneous up and down presses cancel.
    load_val(4'd5);
    check_eq("sim_pre", V, 4'd5);
    press(1'b1, 1'b1);
    check_eq("sim_v", V, 4'd5);
    check_eq("sim_wrap", {3'b000, WRAP}, 4'd0);
    step(1);
    check_eq("sim_v1", V, 4'd5);
    release_keys();

    // Load has priority over a key press and auto ticks; the press is lost.
    SW_D     = 4'b1010;
    SW_LOAD  = 1'b1;
    SW_AUTO  = 1'b1;
    KEY_UP_N = 1'b0;
    step(2);
    check_eq("lp_early", V, 4'd5);
    step(1);
    check_eq("lp_v", V, 4'd10);
    step(17);
    check_eq("lp_hold", V, 4'd10);
    KEY_UP_N = 1'b1;
    step(10);
    SW_LOAD = 1'b0;
    SW_AUTO = 1'b0;
    step(12);
    check_eq("lp_after", V, 4'd10);

    // Auto mode: first increment at edge k+10, then every 8 edges.
    load_val(4'd14);
    SW_AUTO = 1'b1;
    step(10);
    check_eq("auto_early", V, 4'd14);
    step(1);
    check_eq("auto_1", V, 4'd15);
    step(7);
    check_eq("auto_2_early", V, 4'd15);
    step(1);
    check_eq("auto_2", V, 4'd0);
    check_eq("auto_wrap", {3'b000, WRAP}, 4'd1);
    step(1);
    check_eq("auto_wrap1", {3'b000, WRAP}, 4'd0);

    // An up-key event lands on the tick at edge k+26: only one increment.
    KEY_UP_N = 1'b0;
    step(6);
    check_eq("coll_early", V, 4'd0);
    step(1);
    check_eq("coll_v", V, 4'd1);
    step(7);
    check_eq("coll_next_early", V, 4'd1);
    step(1);
    check_eq("coll_next", V, 4'd2);

    // An asynchronous reset mid-cycle clears V from 9 without a clock edge.
    SW_AUTO  = 1'b0;
    KEY_UP_N = 1'b1;
    step(10);
    load_val(4'd9);
    check_eq("pre_rst_v", V, 4'd9);
    #2;
    RESET    = 1'b1;
    KEY_UP_N = 1'b0;
    #1;
    check_eq("arst_v", V, 4'd0);
    check_eq("arst_wrap", {3'b000, WRAP}, 4'd0);

    // Releasing reset with the key held requires a full debounce again.
    step(1);
    RESET = 1'b0;
    step(6);
    check_eq("rst_press_early", V, 4'd0);
    step(1);
    check_eq("rst_press_v", V, 4'd1);
    KEY_UP_N = 1'b1;
    step(10);
    check_eq("rst_press_once", V, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
